// File: rtl/uf_ctrl_if.sv
// Host command bus and flash macro pins of the uf_ctrl sequencer.
// The slave modport is the controller's view; master is the host/flash side.
interface uf_ctrl_if;
  logic        cmd_start;
  logic [1:0]  cmd;
  logic [8:0]  xadr;
  logic [5:0]  yadr;
  logic [31:0] din;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] dout;
  logic [8:0]  uf_xadr;
  logic [5:0]  uf_yadr;
  logic        uf_xe, uf_ye, uf_se, uf_erase, uf_prog, uf_nvstr;
  logic [31:0] uf_din;
  logic [31:0] uf_dout;

  modport master (
    output cmd_start, cmd, xadr, yadr, din, uf_dout,
    input  busy, done, err, dout, uf_xadr, uf_yadr,
           uf_xe, uf_ye, uf_se, uf_erase, uf_prog, uf_nvstr, uf_din
  );
  modport slave (
    input  cmd_start, cmd, xadr, yadr, din, uf_dout,
    output busy, done, err, dout, uf_xadr, uf_yadr,
           uf_xe, uf_ye, uf_se, uf_erase, uf_prog, uf_nvstr, uf_din
  );
endinterface

// File: rtl/uf_ctrl.sv
// Flash macro sequencer: read / word program / page erase with timed strobe phases.
// All macro strobes come straight from flops decoded off the next state.
module uf_ctrl #(
  parameter int unsigned CLOCK_HZ = 50_000_000,
  parameter int unsigned T_NVS    = CLOCK_HZ / 200000,
  parameter int unsigned T_PGS    = CLOCK_HZ / 100000,
  parameter int unsigned T_PROG   = CLOCK_HZ / 100000,
  parameter int unsigned T_ERASE  = CLOCK_HZ / 10,
  parameter int unsigned T_NVH    = CLOCK_HZ / 200000,
  parameter int unsigned T_RCV    = CLOCK_HZ / 100000,
  parameter int unsigned T_RD     = 2
) (
  input logic     clk,
  input logic     rst,
  uf_ctrl_if.slave bus
);

  function automatic int unsigned imax(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned TMAX = imax(imax(imax(T_NVS, T_PGS), imax(T_PROG, T_ERASE)),
                                      imax(imax(T_NVH, T_RCV), T_RD));
  // Counter holds N-1, so clog2(TMAX) bits suffice for the longest phase.
  localparam int unsigned CW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [3:0] {
    IDLE, RD_SETUP, RD_SE, RD_WAIT,
    PG_XE, PG_NVS, PG_PGS, PG_YE, PG_YOFF, PG_NVH,
    ER_XE, ER_NVS, ER_PULSE, ER_NVH, RCV
  } state_e;

  typedef struct packed {
    logic xe, ye, se, erase, prog, nvstr;
  } strb_t;

  function automatic logic [CW-1:0] ld(int unsigned n);
    return (n == 0) ? '0 : CW'(n - 1);
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  strb_t         strb_q, strb_d;
  logic          busy_q, done_q, err_q;
  logic [8:0]    xadr_q;
  logic [5:0]    yadr_q;
  logic [31:0]   din_q, dout_q;
  logic          acc, bad;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc     = 1'b0;
    bad     = 1'b0;
    if (state_q == IDLE) begin
      if (bus.cmd_start) begin
        acc = 1'b1;
        case (bus.cmd)
          2'd0:    state_d = RD_SETUP;
          2'd1:    state_d = PG_XE;
          2'd2:    state_d = ER_XE;
          default: begin acc = 1'b0; bad = 1'b1; end
        endcase
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      case (state_q)
        RD_SETUP: state_d = RD_SE;
        RD_SE:    state_d = RD_WAIT;
        PG_XE:    state_d = PG_NVS;
        PG_NVS:   state_d = PG_PGS;
        PG_PGS:   state_d = PG_YE;
        PG_YE:    state_d = PG_YOFF;
        PG_YOFF:  state_d = PG_NVH;
        ER_XE:    state_d = ER_NVS;
        ER_NVS:   state_d = ER_PULSE;
        ER_PULSE: state_d = ER_NVH;
        PG_NVH,
        ER_NVH:   state_d = RCV;
        default:  state_d = IDLE;
      endcase
    end
    // Every transition lands in a different state, so reload on any change.
    if (state_d != state_q) begin
      case (state_d)
        RD_WAIT:          cnt_d = ld(T_RD);
        PG_NVS, ER_NVS:   cnt_d = ld(T_NVS);
        PG_PGS:           cnt_d = ld(T_PGS);
        PG_YE:            cnt_d = ld(T_PROG);
        ER_PULSE:         cnt_d = ld(T_ERASE);
        PG_NVH, ER_NVH:   cnt_d = ld(T_NVH);
        RCV:              cnt_d = ld(T_RCV);
        default:          cnt_d = '0;
      endcase
    end
  end

  always_comb begin
    strb_d = '0;
    case (state_d)
      RD_SETUP, RD_WAIT: begin strb_d.xe = 1'b1; strb_d.ye = 1'b1; end
      RD_SE:             strb_d.se = 1'b1;
      PG_XE, ER_XE:      strb_d.xe = 1'b1;
      PG_NVS:            begin strb_d.xe = 1'b1; strb_d.prog = 1'b1; end
      PG_PGS, PG_YOFF:   begin strb_d.xe = 1'b1; strb_d.prog = 1'b1; strb_d.nvstr = 1'b1; end
      PG_YE:             begin strb_d.xe = 1'b1; strb_d.prog = 1'b1; strb_d.nvstr = 1'b1;
                               strb_d.ye = 1'b1; end
      ER_NVS:            begin strb_d.xe = 1'b1; strb_d.erase = 1'b1; end
      ER_PULSE:          begin strb_d.xe = 1'b1; strb_d.erase = 1'b1; strb_d.nvstr = 1'b1; end
      PG_NVH, ER_NVH:    begin strb_d.xe = 1'b1; strb_d.nvstr = 1'b1; end
      default:           strb_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      strb_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      xadr_q  <= '0;
      yadr_q  <= '0;
      din_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      strb_q  <= strb_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_q != IDLE) && (state_d == IDLE);
      err_q   <= bad;
      if (acc) begin
        xadr_q <= bus.xadr;
        yadr_q <= bus.yadr;
        din_q  <= bus.din;
      end
      if (state_q == RD_WAIT && cnt_q == '0) dout_q <= bus.uf_dout;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.dout     = dout_q;
  assign bus.uf_xadr  = xadr_q;
  assign bus.uf_yadr  = yadr_q;
  assign bus.uf_din   = din_q;
  assign bus.uf_xe    = strb_q.xe;
  assign bus.uf_ye    = strb_q.ye;
  assign bus.uf_se    = strb_q.se;
  assign bus.uf_erase = strb_q.erase;
  assign bus.uf_prog  = strb_q.prog;
  assign bus.uf_nvstr = strb_q.nvstr;

endmodule

// File: tb/tb_uf_ctrl.sv
// Bench for uf_ctrl: expected per-cycle strobe/busy/done/err trace is built from
// the phase lists of each command and compared cycle by cycle.
module tb_uf_ctrl;
  localparam int unsigned T_NVS = 3, T_PGS = 4, T_PROG = 5, T_ERASE = 20;
  localparam int unsigned T_NVH = 3, T_RCV = 2, T_RD = 2;

  localparam logic [5:0] XE = 6'b100000, YE = 6'b010000, SE = 6'b001000;
  localparam logic [5:0] ER = 6'b000100, PG = 6'b000010, NV = 6'b000001;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic [5:0] strb;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] flash_q = '0;
  int n_chk = 0, n_pass = 0;

  obs_t        exp_q[$];
  logic [31:0] exp_dout = '0, exp_din = '0;
  logic [8:0]  exp_xadr = '0;
  logic [5:0]  exp_yadr = '0;

  uf_ctrl_if bus();
  assign bus.uf_dout = flash_q;

  uf_ctrl #(
    .T_NVS(T_NVS), .T_PGS(T_PGS), .T_PROG(T_PROG), .T_ERASE(T_ERASE),
    .T_NVH(T_NVH), .T_RCV(T_RCV), .T_RD(T_RD)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic obs_t obs();
    obs_t o;
    o.busy = bus.busy;
    o.done = bus.done;
    o.err  = bus.err;
    o.strb = {bus.uf_xe, bus.uf_ye, bus.uf_se, bus.uf_erase, bus.uf_prog, bus.uf_nvstr};
    return o;
  endfunction

  function automatic void seg(input logic [5:0] s, input int unsigned n);
    obs_t o;
    o.busy = 1'b1; o.done = 1'b0; o.err = 1'b0; o.strb = s;
    for (int i = 0; i < ((n < 1) ? 1 : int'(n)); i++) exp_q.push_back(o);
  endfunction

  function automatic void build(input logic [1:0] c);
    exp_q.delete();
    case (c)
      2'd0: begin
        seg(XE|YE, 1); seg(SE, 1); seg(XE|YE, T_RD);
      end
      2'd1: begin
        seg(XE, 1); seg(XE|PG, T_NVS); seg(XE|PG|NV, T_PGS); seg(XE|PG|NV|YE, T_PROG);
        seg(XE|PG|NV, 1); seg(XE|NV, T_NVH); seg(6'b0, T_RCV);
      end
      2'd2: begin
        seg(XE, 1); seg(XE|ER, T_NVS); seg(XE|ER|NV, T_ERASE); seg(XE|NV, T_NVH);
        seg(6'b0, T_RCV);
      end
      default: ;
    endcase
    if (c == 2'd3) exp_q.push_back(obs_t'(9'b001_000000));
    else           exp_q.push_back(obs_t'(9'b010_000000));
    exp_q.push_back(obs_t'(9'b0));
  endfunction

  // inj: trace index at which a stray cmd_start is driven (<0 for none)
  task automatic do_cmd(input logic [1:0] c, input logic [8:0] x, input logic [5:0] y,
                        input logic [31:0] d, input int inj);
    int nbusy;
    build(c);
    nbusy = exp_q.size() - 2;
    @(negedge clk);
    bus.cmd_start = 1'b1; bus.cmd = c; bus.xadr = x; bus.yadr = y; bus.din = d;
    @(posedge clk);
    #1 bus.cmd_start = 1'b0;
    if (c != 2'd3) begin exp_xadr = x; exp_yadr = y; exp_din = d; end
    if (c == 2'd0) exp_dout = flash_q;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      chk($sformatf("cmd%0d_cyc%0d", c, i), 64'(obs()), 64'(exp_q[i]));
      if (i == inj && i < nbusy) begin
        bus.cmd_start = 1'b1;
        bus.cmd  = 2'($urandom_range(0, 3));
        bus.xadr = 9'($urandom); bus.yadr = 6'($urandom); bus.din = $urandom;
      end else begin
        bus.cmd_start = 1'b0;
      end
    end
    bus.cmd_start = 1'b0;
    chk($sformatf("cmd%0d_dout", c), 64'(bus.dout), 64'(exp_dout));
    chk($sformatf("cmd%0d_xadr", c), 64'(bus.uf_xadr), 64'(exp_xadr));
    chk($sformatf("cmd%0d_yadr", c), 64'(bus.uf_yadr), 64'(exp_yadr));
    chk($sformatf("cmd%0d_din", c), 64'(bus.uf_din), 64'(exp_din));
  endtask

  initial begin
    bus.cmd_start = 1'b0; bus.cmd = '0; bus.xadr = '0; bus.yadr = '0; bus.din = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_obs", 64'(obs()), 64'(0));
    chk("rst_dout", 64'(bus.dout), 64'(0));
    chk("rst_xadr", 64'(bus.uf_xadr), 64'(0));
    chk("rst_yadr", 64'(bus.uf_yadr), 64'(0));
    chk("rst_din", 64'(bus.uf_din), 64'(0));
    rst = 1'b0;

    flash_q = 32'hDEADBEEF;
    do_cmd(2'd0, 9'd5, 6'd7, 32'h0, -1);
    flash_q = 32'h0BADF00D;
    do_cmd(2'd1, 9'd1, 6'd2, 32'h12345678, 6);
    do_cmd(2'd2, 9'd3, 6'd0, 32'h0, -1);
    do_cmd(2'd3, 9'd9, 6'd9, 32'hFFFF0000, -1);

    for (int k = 0; k < 20; k++) begin
      flash_q = $urandom;
      do_cmd(2'($urandom_range(0, 3)), 9'($urandom), 6'($urandom), $urandom,
             (k % 3 == 0) ? int'($urandom_range(0, 3)) : -1);
    end

    // Abort an erase in the middle of its pulse with reset.
    @(negedge clk);
    bus.cmd_start = 1'b1; bus.cmd = 2'd2; bus.xadr = 9'd44; bus.yadr = 6'd1;
    @(posedge clk);
    #1 bus.cmd_start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_pre", 64'(obs()), 64'({1'b1, 2'b00, XE|ER|NV}));
    rst = 1'b1;
    bus.cmd_start = 1'b1; bus.cmd = 2'd0;
    @(negedge clk);
    chk("abort_obs", 64'(obs()), 64'(0));
    chk("abort_xadr", 64'(bus.uf_xadr), 64'(0));
    chk("abort_dout", 64'(bus.dout), 64'(0));
    rst = 1'b0;
    bus.cmd_start = 1'b0;
    @(negedge clk);
    chk("abort_idle", 64'(obs()), 64'(0));
    exp_dout = '0; exp_xadr = '0; exp_yadr = '0; exp_din = '0;
    flash_q = 32'hCAFEF00D;
    do_cmd(2'd0, 9'd300, 6'd33, 32'h0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
